// File: rtl/uart_rx_ext_if.sv
// uart_rx_ext_if -- receive-side word handshake between the UART receiver and
// its consumer.
//   o_data        received word, LSB first on the line
//   o_valid       word and status flags are valid
//   i_ready       consumer accepts the word (handshake = o_valid && i_ready)
//   o_parity_err  per-word parity error
//   o_frame_err   per-word framing error (any stop bit low, or break)
//   o_break       per-word break (all-zero frame)
//   o_overrun     sticky: a completed frame was dropped
//   o_busy        receiver is inside a frame
interface uart_rx_ext_if #(
  parameter int N_DATA = 8
);
  logic [N_DATA-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_parity_err;
  logic              o_frame_err;
  logic              o_break;
  logic              o_overrun;
  logic              o_busy;

  modport master (
    output o_data, o_valid, o_parity_err, o_frame_err, o_break, o_overrun, o_busy,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_parity_err, o_frame_err, o_break, o_overrun, o_busy,
    output i_ready
  );
endinterface

// File: rtl/uart_rx_ext.sv
// uart_rx_ext -- oversampling UART receiver with parity, multi-stop, break
// detection and a one-word holding register with overrun reporting.
//   i_clock    single clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_data     serial line, idle high, asynchronous to i_clock
//   i_valid    oversample tick enable (OVERSAMPLE ticks per bit)
//   bus        word/status handshake (uart_rx_ext_if.master)
module uart_rx_ext #(
  parameter int N_DATA      = 8,
  parameter int PARITY_MODE = 0,   // 0 none, 1 even, 2 odd
  parameter int M_STOP      = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic           i_clock,
  input  logic           i_reset_n,
  input  logic           i_data,
  input  logic           i_valid,
  uart_rx_ext_if.master  bus
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] T_DEC = TW'(OVERSAMPLE/2 + 1);

  logic              sync1_q, sync2_q;
  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [3:0]        bit_q, bit_d;
  logic [N_DATA-1:0] shift_q, shift_d;
  logic [1:0]        samp_q, samp_d;
  logic              par_q, par_d;
  logic              stop0_q, stop0_d;   // value of the first stop bit
  logic              sbad_q, sbad_d;     // some stop bit seen low so far
  logic [N_DATA-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              fe_q, fe_d;
  logic              brk_q, brk_d;
  logic              ovr_q, ovr_d;
  logic              busy_q, busy_d;

  logic              rxd, maj, done, hs, first_stop, stop_bad, brk_w, pxor;
  logic [TW-1:0]     tick_nx;

  assign rxd = sync2_q;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    samp_d  = samp_q;
    par_d   = par_q;
    stop0_d = stop0_q;
    sbad_d  = sbad_q;
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    fe_d    = fe_q;
    brk_d   = brk_q;
    ovr_d   = ovr_q;
    done    = 1'b0;

    // Tick index of the current i_valid cycle; natural wrap marks bit edges.
    tick_nx    = tick_q + 1'b1;
    maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd) | (samp_q[1] & rxd);
    first_stop = (bit_q == 4'd0) ? maj : stop0_q;
    stop_bad   = sbad_q | ~maj;
    brk_w      = (shift_q == '0) && ((PARITY_MODE == 0) || !par_q) && !first_stop;
    pxor       = (^shift_q) ^ par_q;

    if (i_valid) begin
      if (state_q == S_IDLE) begin
        if (!rxd) begin
          state_d = S_START;
          tick_d  = '0;
          sbad_d  = 1'b0;
        end
      end else begin
        tick_d = tick_nx;
        if (tick_nx == T_S0) samp_d[0] = rxd;
        if (tick_nx == T_S1) samp_d[1] = rxd;
        case (state_q)
          S_START: begin
            if (tick_nx == T_DEC && maj) state_d = S_IDLE;   // false start
            else if (tick_nx == '0) begin
              state_d = S_DATA;
              bit_d   = '0;
            end
          end
          S_DATA: begin
            if (tick_nx == T_DEC) begin
              shift_d = {maj, shift_q[N_DATA-1:1]};
              bit_d   = bit_q + 4'd1;
            end else if (tick_nx == '0 && bit_q == 4'(N_DATA)) begin
              bit_d   = '0;
              state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end
          end
          S_PARITY: begin
            if (tick_nx == T_DEC) par_d = maj;
            else if (tick_nx == '0) state_d = S_STOP;
          end
          S_STOP: begin
            if (tick_nx == T_DEC) begin
              stop0_d = first_stop;
              sbad_d  = stop_bad;
              bit_d   = bit_q + 4'd1;
              // Leave mid-bit so the next start edge can be caught early.
              if (bit_q == 4'(M_STOP - 1)) begin
                done    = 1'b1;
                state_d = S_IDLE;
                bit_d   = '0;
              end
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    hs = valid_q && bus.i_ready;
    if (hs) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done) begin
      if (valid_q && !bus.i_ready) begin
        ovr_d = 1'b1;                 // held word wins, new frame dropped
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
        perr_d  = (PARITY_MODE == 1) ? pxor : (PARITY_MODE == 2) ? ~pxor : 1'b0;
        brk_d   = brk_w;
        fe_d    = stop_bad | brk_w;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      samp_q  <= '0;
      par_q   <= 1'b0;
      stop0_q <= 1'b0;
      sbad_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= i_data;
      sync2_q <= sync1_q;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      samp_q  <= samp_d;
      par_q   <= par_d;
      stop0_q <= stop0_d;
      sbad_q  <= sbad_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      fe_q    <= fe_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_parity_err = perr_q;
  assign bus.o_frame_err  = fe_q;
  assign bus.o_break      = brk_q;
  assign bus.o_overrun    = ovr_q;
  assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
module tb_uart_rx_ext;
  localparam int OS = 16;

  logic clk = 1'b0, rst_n = 1'b0, line_a = 1'b1, line_b = 1'b1, vld = 1'b0, rdy = 1'b1;
  always #5 clk = ~clk;

  uart_rx_ext_if #(.N_DATA(8)) ifa ();
  uart_rx_ext_if #(.N_DATA(7)) ifb ();
  assign ifa.i_ready = rdy;
  assign ifb.i_ready = rdy;

  uart_rx_ext #(.N_DATA(8), .PARITY_MODE(0), .M_STOP(1), .OVERSAMPLE(OS)) dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_data(line_a), .i_valid(vld), .bus(ifa));
  uart_rx_ext #(.N_DATA(7), .PARITY_MODE(2), .M_STOP(2), .OVERSAMPLE(OS)) dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_data(line_b), .i_valid(vld), .bus(ifb));

  typedef struct { logic [8:0] d; logic pe, fe, br; } word_t;
  typedef struct {
    bit sel_b; logic [8:0] d; bit flip; logic [1:0] stops;
    logic [8:0] ed; logic epe, efe, ebr;
  } vec_t;

  word_t rx_a[$], rx_b[$], exp_a[$], exp_b[$];
  int checks = 0, failures = 0;
  int dense = 100;
  bit rdy_rand = 1'b0;

  // Words accepted by the consumer; inputs change #1 after posedge so the
  // negedge view is what the next edge will see.
  always @(negedge clk) begin
    word_t w;
    if (rst_n && ifa.o_valid && rdy) begin
      w.d = {1'b0, ifa.o_data}; w.pe = ifa.o_parity_err; w.fe = ifa.o_frame_err; w.br = ifa.o_break;
      rx_a.push_back(w);
    end
    if (rst_n && ifb.o_valid && rdy) begin
      w.d = {2'b0, ifb.o_data}; w.pe = ifb.o_parity_err; w.fe = ifb.o_frame_err; w.br = ifb.o_break;
      rx_b.push_back(w);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Hold the line at b for n oversample ticks (i_valid cycles).
  task automatic tick(input bit b, input bit sel_b, input int n);
    int c = 0;
    while (c < n) begin
      vld = (dense >= 100) ? 1'b1 : ($urandom_range(0, 99) < 32'(dense));
      if (rdy_rand) rdy = ($urandom_range(0, 3) != 0);
      if (sel_b) line_b = b; else line_a = b;
      @(posedge clk); #1;
      if (vld) c++;
    end
  endtask

  // Send one frame and, if asked, queue the word the line protocol implies.
  task automatic send(input bit sel_b, input logic [8:0] d, input bit flip_par,
                      input logic [1:0] stops, input bit record);
    int nd = sel_b ? 7 : 8;
    int pm = sel_b ? 2 : 0;
    int ms = sel_b ? 2 : 1;
    logic [8:0] dm;
    logic pb, szero;
    word_t e;
    dm = d & ((9'h1 << nd) - 9'h1);
    pb = (pm == 1) ? ^dm : ~^dm;
    if (flip_par) pb = ~pb;
    tick(1'b0, sel_b, OS);
    for (int i = 0; i < nd; i++) tick(dm[i], sel_b, OS);
    if (pm != 0) tick(pb, sel_b, OS);
    for (int i = 0; i < ms; i++) tick(stops[i], sel_b, OS);
    tick(1'b1, sel_b, 2*OS);
    szero = !stops[0] || (ms == 2 && !stops[1]);
    e.d  = dm;
    e.br = (dm == 0) && (pm == 0 || !pb) && !stops[0];
    e.pe = (pm == 0) ? 1'b0 : (pm == 1) ? ((^dm ^ pb) != 0) : ((^dm ^ pb) == 0);
    e.fe = szero || e.br;
    if (record) begin
      if (sel_b) exp_b.push_back(e); else exp_a.push_back(e);
    end
  endtask

  task automatic cmp_q(input string nm, input bit sel_b);
    word_t g, e;
    if (sel_b) chk({nm, "_count"}, rx_b.size(), exp_b.size());
    else       chk({nm, "_count"}, rx_a.size(), exp_a.size());
    for (int i = 0; i < 64; i++) begin
      if (sel_b) begin
        if (rx_b.size() == 0 || exp_b.size() == 0) break;
        g = rx_b.pop_front(); e = exp_b.pop_front();
      end else begin
        if (rx_a.size() == 0 || exp_a.size() == 0) break;
        g = rx_a.pop_front(); e = exp_a.pop_front();
      end
      chk({nm, "_data"}, g.d, e.d);
      chk({nm, "_perr"}, g.pe, e.pe);
      chk({nm, "_ferr"}, g.fe, e.fe);
      chk({nm, "_brk"},  g.br, e.br);
    end
    rx_a.delete(); rx_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  initial begin
    #2ms;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vec_t tbl[9];
    word_t w;
    tbl[0] = '{0, 9'hA5, 0, 2'b11, 9'hA5, 0, 0, 0};
    tbl[1] = '{0, 9'h00, 0, 2'b10, 9'h00, 0, 1, 1};
    tbl[2] = '{0, 9'hFF, 0, 2'b10, 9'hFF, 0, 1, 0};
    tbl[3] = '{0, 9'h5A, 0, 2'b11, 9'h5A, 0, 0, 0};
    tbl[4] = '{1, 9'h3C, 1, 2'b11, 9'h3C, 1, 0, 0};
    tbl[5] = '{1, 9'h3C, 0, 2'b11, 9'h3C, 0, 0, 0};
    tbl[6] = '{1, 9'h7F, 0, 2'b01, 9'h7F, 0, 1, 0};
    tbl[7] = '{1, 9'h00, 1, 2'b00, 9'h00, 1, 1, 1};
    tbl[8] = '{1, 9'h00, 0, 2'b00, 9'h00, 0, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ifa.o_valid, 0);
    chk("rst_data",  ifa.o_data, 0);
    chk("rst_busy",  ifa.o_busy, 0);
    chk("rst_ovr",   ifa.o_overrun, 0);
    chk("rst_flags", {ifa.o_parity_err, ifa.o_frame_err, ifa.o_break}, 0);
    chk("rst_b_data", ifb.o_data, 0);
    rst_n = 1'b1;
    tick(1'b1, 0, 2*OS);
    chk("idle_busy", ifa.o_busy, 0);
    chk("idle_none", rx_a.size(), 0);

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      rx_a.delete(); rx_b.delete();
      send(tbl[i].sel_b, tbl[i].d, tbl[i].flip, tbl[i].stops, 0);
      tick(1'b1, tbl[i].sel_b, OS);
      if (tbl[i].sel_b) begin
        chk($sformatf("vec%0d_count", i), rx_b.size(), 1);
        if (rx_b.size() > 0) w = rx_b[0];
      end else begin
        chk($sformatf("vec%0d_count", i), rx_a.size(), 1);
        if (rx_a.size() > 0) w = rx_a[0];
      end
      chk($sformatf("vec%0d_data", i), w.d, tbl[i].ed);
      chk($sformatf("vec%0d_flags", i), {w.pe, w.fe, w.br}, {tbl[i].epe, tbl[i].efe, tbl[i].ebr});
    end
    rx_a.delete(); rx_b.delete();

    // Long break, then a clean frame
    tick(1'b0, 0, 12*OS);
    tick(1'b1, 0, 12*OS);
    send(0, 9'h55, 0, 2'b11, 0);
    chk("brk_count_min", rx_a.size() >= 2, 1);
    if (rx_a.size() >= 2) begin
      chk("brk_word", {rx_a[0].d, rx_a[0].pe, rx_a[0].fe, rx_a[0].br}, {9'h0, 3'b011});
      w = rx_a[rx_a.size()-1];
      chk("brk_after", {w.d, w.pe, w.fe, w.br}, {9'h55, 3'b000});
    end
    rx_a.delete();

    // Overrun: three frames with no consumer
    rdy = 1'b0;
    send(0, 9'h11, 0, 2'b11, 0);
    chk("ovr_first", ifa.o_overrun, 0);
    send(0, 9'h22, 0, 2'b11, 0);
    send(0, 9'h33, 0, 2'b11, 0);
    chk("ovr_valid", ifa.o_valid, 1);
    chk("ovr_data",  ifa.o_data, 8'h11);
    chk("ovr_flag",  ifa.o_overrun, 1);
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    chk("ovr_hs_valid", ifa.o_valid, 0);
    chk("ovr_hs_flag",  ifa.o_overrun, 0);
    chk("ovr_hs_word",  rx_a.size() == 1 && rx_a[0].d == 9'h11, 1);
    rx_a.delete();
    rdy = 1'b1;

    // Short glitch is a false start
    tick(1'b0, 0, 3);
    tick(1'b1, 0, 3*OS);
    chk("glitch_none", rx_a.size(), 0);
    chk("glitch_busy", ifa.o_busy, 0);
    send(0, 9'h81, 0, 2'b11, 0);
    chk("glitch_next", rx_a.size() == 1 && rx_a[0].d == 9'h81 && !rx_a[0].fe, 1);
    rx_a.delete();

    // Reset in data bit 4 with a held word and overrun pending
    rdy = 1'b0;
    send(0, 9'h42, 0, 2'b11, 0);
    send(0, 9'h43, 0, 2'b11, 0);
    tick(1'b0, 0, OS);
    for (int i = 0; i < 4; i++) tick(i[0], 0, OS);
    tick(1'b1, 0, OS/2);
    chk("mid_busy", ifa.o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", ifa.o_valid, 0);
    chk("arst_data",  ifa.o_data, 0);
    chk("arst_ovr",   ifa.o_overrun, 0);
    chk("arst_busy",  ifa.o_busy, 0);
    line_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy = 1'b1;
    tick(1'b1, 0, 12*OS);
    chk("arst_none", rx_a.size(), 0);
    chk("arst_valid2", ifa.o_valid, 0);

    // Randomized traffic against the model
    rdy_rand = 1'b1;
    for (int n = 0; n < 20; n++) begin
      dense = $urandom_range(40, 100);
      send(0, 9'($urandom), 0, ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b11, 1);
    end
    for (int n = 0; n < 12; n++) begin
      dense = $urandom_range(40, 100);
      send(1, 9'($urandom), ($urandom_range(0, 3) == 0),
           {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)}, 1);
    end
    rdy_rand = 1'b0;
    rdy = 1'b1;
    dense = 100;
    tick(1'b1, 0, 2*OS);
    cmp_q("rand", 0);
    for (int n = 0; n < 12; n++) begin
      dense = $urandom_range(40, 100);
      send(1, 9'($urandom), ($urandom_range(0, 3) == 0),
           {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)}, 1);
    end
    dense = 100;
    tick(1'b1, 1, 2*OS);
    cmp_q("rand_b", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
